serial_cmp_lsb_first: RTL and testbench

//   Bit-serial magnitude comparator that scans two N-bit words right-to-left (LSB first).
//   It is the opposite scan direction to the MSB-first combinational CableadoBit chain.

---
 rtl/serial_cmp_lsb_first_pkg.sv | 29 ++
 rtl/serial_cmp_lsb_first_if.sv | 24 ++
 rtl/serial_cmp_lsb_first_piso.sv | 34 +++
 rtl/serial_cmp_lsb_first.sv | 106 ++++++++++
 tb/tb_serial_cmp_lsb_first.sv | 143 ++++++++++++++
 5 files changed

// File: rtl/serial_cmp_lsb_first_pkg.sv
// Shared encodings and the per-bit decision helper for the LSB-first serial comparator.
package serial_cmp_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [1:0] RES_EQ = 2'd0;
    localparam logic [1:0] RES_GT = 2'd1;
    localparam logic [1:0] RES_LT = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_SHIFT = ST_SHIFT,
        S_DONE  = ST_DONE
    } state_t;

    // Equal bits give RES_EQ, meaning "leave the running result alone".
    function automatic logic [1:0] res_from_bits(input logic a_bit, input logic b_bit,
                                                 input logic invert);
        if (a_bit == b_bit)
            return RES_EQ;
        else if (a_bit ^ invert)
            return RES_GT;
        else
            return RES_LT;
    endfunction

endpackage

// File: rtl/serial_cmp_lsb_first_if.sv
// Operand/result bundle between a requester and the serial comparator.
interface serial_cmp_if #(parameter int N = 16) ();

    logic                 start;
    logic [N-1:0]         a;
    logic [N-1:0]         b;
    logic                 busy;
    logic                 done;
    logic                 a_gt_b;
    logic                 a_lt_b;
    logic                 a_eq_b;
    logic [$clog2(N)-1:0] bit_idx;

    modport master (
        output start, a, b,
        input  busy, done, a_gt_b, a_lt_b, a_eq_b, bit_idx
    );

    modport slave (
        input  start, a, b,
        output busy, done, a_gt_b, a_lt_b, a_eq_b, bit_idx
    );

endinterface

// File: rtl/serial_cmp_lsb_first_piso.sv
// Parallel-load, shift-right register pair presenting the current LSBs of both operands.
module piso_pair #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         shift,
    input  logic [N-1:0] a_in,
    input  logic [N-1:0] b_in,
    output logic         sa0,
    output logic         sb0
);

    logic [N-1:0] sa;
    logic [N-1:0] sb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa <= '0;
            sb <= '0;
        end else if (load) begin
            sa <= a_in;
            sb <= b_in;
        end else if (shift) begin
            sa <= {1'b0, sa[N-1:1]};
            sb <= {1'b0, sb[N-1:1]};
        end
    end

    assign sa0 = sa[0];
    assign sb0 = sb[0];

endmodule

// File: rtl/serial_cmp_lsb_first.sv
// LSB-first bit-serial magnitude comparator; N+1 cycles per compare, no early exit.
// Define CMP_SIGNED_EN to compare two's complement operands (sign bit sense inverted).
import serial_cmp_pkg::*;

module serial_cmp_lsb_first #(
    parameter int N = 16
) (
    input logic        clk,
    input logic        rst_n,
    serial_cmp_if.slave bus
);

    localparam int W = $clog2(N);
    localparam logic [W-1:0] LAST = W'(N - 1);

`ifdef CMP_SIGNED_EN
    localparam logic SIGNED_CMP = 1'b1;
`else
    localparam logic SIGNED_CMP = 1'b0;
`endif

    state_t      state;
    logic [W-1:0] cnt;
    logic [1:0]  res;
    logic        sa0;
    logic        sb0;
    logic        load;
    logic        shift;
    logic        last_pair;
    logic [1:0]  pair_res;
    logic        busy;
    logic        done;
    logic        a_gt_b;
    logic        a_lt_b;
    logic        a_eq_b;

    assign load      = (state == S_IDLE) && bus.start;
    assign shift     = (state == S_SHIFT);
    assign last_pair = (cnt == LAST);
    assign pair_res  = res_from_bits(sa0, sb0, SIGNED_CMP && last_pair);

    piso_pair #(.N(N)) u_piso (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .shift (shift),
        .a_in  (bus.a),
        .b_in  (bus.b),
        .sa0   (sa0),
        .sb0   (sb0)
    );

    // Later (more significant) differing pairs overwrite the running result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            res    <= RES_EQ;
            busy   <= 1'b0;
            done   <= 1'b0;
            a_gt_b <= 1'b0;
            a_lt_b <= 1'b0;
            a_eq_b <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        res    <= RES_EQ;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        a_gt_b <= 1'b0;
                        a_lt_b <= 1'b0;
                        a_eq_b <= 1'b0;
                        state  <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (pair_res != RES_EQ)
                        res <= pair_res;
                    cnt <= cnt + 1'b1;
                    if (last_pair) begin
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done   <= 1'b1;
                    a_gt_b <= (res == RES_GT);
                    a_lt_b <= (res == RES_LT);
                    a_eq_b <= (res == RES_EQ);
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.a_gt_b  = a_gt_b;
    assign bus.a_lt_b  = a_lt_b;
    assign bus.a_eq_b  = a_eq_b;
    assign bus.bit_idx = (state == S_SHIFT) ? cnt : '0;

endmodule

// File: tb/tb_serial_cmp_lsb_first.sv
// Directed bench for serial_cmp_lsb_first (N=16); expectations follow CMP_SIGNED_EN.
module tb_serial_cmp_lsb_first;

    localparam int N = 16;

`ifdef CMP_SIGNED_EN
    localparam logic SGN = 1'b1;
`else
    localparam logic SGN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   error_count = 0;
    int   check_count = 0;
    int   done_pulses = 0;
    int   p0;
    int   waited;

    serial_cmp_if #(.N(N)) bus ();

    serial_cmp_lsb_first #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bus.done === 1'b1) done_pulses++;

    task automatic check_output(input string tag, input logic [31:0] actual,
                                input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Runs one compare; lat counts rising edges after the one that accepted start.
    task automatic apply_stimulus(input string tag, input logic [15:0] av,
                                  input logic [15:0] bv, input logic gt,
                                  input logic lt, input logic eq);
        int lat;
        int busy_cycles;
        @(negedge clk);
        bus.a     = av;
        bus.b     = bv;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        lat = 0;
        busy_cycles = 0;
        @(negedge clk);
        check_output({tag, " flags_clear"}, {bus.a_gt_b, bus.a_lt_b, bus.a_eq_b}, 3'b000);
        while (bus.done !== 1'b1 && lat < 40) begin
            if (bus.busy === 1'b1) busy_cycles++;
            if (lat == 5)     check_output({tag, " bit_idx5"}, bus.bit_idx, 5);
            if (lat == N - 1) check_output({tag, " bit_idx15"}, bus.bit_idx, 15);
            @(negedge clk);
            lat++;
        end
        check_output({tag, " latency"}, lat, 17);
        check_output({tag, " busy_cycles"}, busy_cycles, 16);
        check_output({tag, " busy_at_done"}, bus.busy, 0);
        check_output({tag, " flags"}, {bus.a_gt_b, bus.a_lt_b, bus.a_eq_b}, {gt, lt, eq});
        @(negedge clk);
        check_output({tag, " done_pulse"}, bus.done, 0);
        check_output({tag, " flags_hold"}, {bus.a_gt_b, bus.a_lt_b, bus.a_eq_b}, {gt, lt, eq});
    endtask

    initial begin
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        rst_n     = 1'b0;
        #1;
        check_output("reset_outputs",
                     {bus.busy, bus.done, bus.a_gt_b, bus.a_lt_b, bus.a_eq_b, bus.bit_idx}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_output("idle_bit_idx", bus.bit_idx, 0);

        apply_stimulus("t1", 16'hDABF, 16'h6D5A, !SGN, SGN, 1'b0);
        apply_stimulus("t2", 16'h1234, 16'h1234, 1'b0, 1'b0, 1'b1);
        apply_stimulus("t3a", 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0);
        apply_stimulus("t3b", 16'h8001, 16'h0003, !SGN, SGN, 1'b0);
        apply_stimulus("t4", 16'h8000, 16'h7FFF, !SGN, SGN, 1'b0);

        // Second start mid-compare with new operands must be ignored.
        p0 = done_pulses;
        @(negedge clk);
        bus.a     = 16'h0003;
        bus.b     = 16'h0010;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        bus.a     = 16'hFFFF;
        bus.b     = 16'h0000;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        waited = 0;
        @(negedge clk);
        while (bus.done !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check_output("t5 done_seen", bus.done, 1);
        check_output("t5 flags", {bus.a_gt_b, bus.a_lt_b, bus.a_eq_b}, 3'b010);
        repeat (20) @(negedge clk);
        check_output("t5 done_count", done_pulses - p0, 1);

        // Reset in the middle of a compare.
        @(negedge clk);
        bus.a     = 16'hFFFF;
        bus.b     = 16'h0000;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check_output("t6 busy_before", bus.busy, 1);
        #1 rst_n = 1'b0;
        #1;
        check_output("t6 reset_outputs",
                     {bus.busy, bus.done, bus.a_gt_b, bus.a_lt_b, bus.a_eq_b, bus.bit_idx}, 0);
        p0 = done_pulses;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check_output("t6 no_done", done_pulses - p0, 0);
        apply_stimulus("t6", 16'h0005, 16'h0009, 1'b0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
